// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits on load data,
// aligns load results and drives the register file, bypass and trace ports.
module wb_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ms_valid,
  output logic        wb_allowin,
  input  logic [31:0] ms_pc,
  input  logic [4:0]  ms_dest,
  input  logic        ms_rf_we,
  input  logic [31:0] ms_res,
  input  logic        ms_is_load,
  input  logic [2:0]  ms_ld_type,
  input  logic [1:0]  ms_addr_low,
  input  logic [31:0] ms_rt_old,
  input  logic        data_ok,
  input  logic [31:0] data_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        fwd_stall,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] retired_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        rf_we;
    logic [31:0] res;
    logic        is_load;
    logic [2:0]  ld_type;
    logic [1:0]  addr_low;
    logic [31:0] rt_old;
  } ws_t;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  ws_t         ws;
  logic        ready_go;
  logic        dest_nz;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;
  logic [31:0] ld_val;

  assign ready_go   = !ws.is_load || data_ok;
  assign wb_allowin = !ws.valid || ready_go;
  assign dest_nz    = ws.dest != 5'd0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ws          <= '0;
      retired_cnt <= '0;
    end else begin
      if (ws.valid && ready_go)
        retired_cnt <= retired_cnt + 32'd1;
      if (wb_allowin)
        ws.valid <= ms_valid;
      if (ms_valid && wb_allowin) begin
        ws.pc       <= ms_pc;
        ws.dest     <= ms_dest;
        ws.rf_we    <= ms_rf_we;
        ws.res      <= ms_res;
        ws.is_load  <= ms_is_load;
        ws.ld_type  <= ms_ld_type;
        ws.addr_low <= ms_addr_low;
        ws.rt_old   <= ms_rt_old;
      end
    end
  end

  // lane selection for sub-word and unaligned loads
  always_comb begin
    bsel    = data_rdata[7:0];
    lwl_val = data_rdata;
    lwr_val = data_rdata;
    unique case (ws.addr_low)
      2'd0: begin
        bsel    = data_rdata[7:0];
        lwl_val = {data_rdata[7:0], ws.rt_old[23:0]};
        lwr_val = data_rdata;
      end
      2'd1: begin
        bsel    = data_rdata[15:8];
        lwl_val = {data_rdata[15:0], ws.rt_old[15:0]};
        lwr_val = {ws.rt_old[31:24], data_rdata[31:8]};
      end
      2'd2: begin
        bsel    = data_rdata[23:16];
        lwl_val = {data_rdata[23:0], ws.rt_old[7:0]};
        lwr_val = {ws.rt_old[31:16], data_rdata[31:16]};
      end
      2'd3: begin
        bsel    = data_rdata[31:24];
        lwl_val = data_rdata;
        lwr_val = {ws.rt_old[31:8], data_rdata[31:24]};
      end
      default: ;
    endcase
    hsel = ws.addr_low[1] ? data_rdata[31:16]
                          : data_rdata[15:0];
  end

  always_comb begin
    ld_val = data_rdata;
    case (ws.ld_type)
      LD_LW:   ld_val = data_rdata;
      LD_LB:   ld_val = {{24{bsel[7]}}, bsel};
      LD_LBU:  ld_val = {24'd0, bsel};
      LD_LH:   ld_val = {{16{hsel[15]}}, hsel};
      LD_LHU:  ld_val = {16'd0, hsel};
      LD_LWL:  ld_val = lwl_val;
      LD_LWR:  ld_val = lwr_val;
      default: ld_val = data_rdata;
    endcase
  end

  assign rf_wdata = ws.is_load ? ld_val : ws.res;
  assign rf_waddr = ws.dest;
  assign rf_wen   = ws.valid && ws.rf_we && ready_go
                    && dest_nz;

  assign fwd_valid = ws.valid && ws.rf_we && dest_nz;
  assign fwd_dest  = fwd_valid ? ws.dest : 5'd0;
  assign fwd_data  = rf_wdata;
  assign fwd_stall = fwd_valid && ws.is_load && !data_ok;

  assign debug_wb_pc       = ws.pc;
  assign debug_wb_rf_wen   = {4{rf_wen}};
  assign debug_wb_rf_wnum  = ws.dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed load/alignment cases, a held
// load, reset mid-load, then randomized traffic against a reference model.
module tb_wb_stage;

  logic        clk;
  logic        rstn;
  logic        ms_valid;
  logic        wb_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic        ms_rf_we;
  logic [31:0] ms_res;
  logic        ms_is_load;
  logic [2:0]  ms_ld_type;
  logic [1:0]  ms_addr_low;
  logic [31:0] ms_rt_old;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retired_cnt;

  wb_stage dut (
    .clk(clk), .rstn(rstn),
    .ms_valid(ms_valid), .wb_allowin(wb_allowin),
    .ms_pc(ms_pc), .ms_dest(ms_dest),
    .ms_rf_we(ms_rf_we), .ms_res(ms_res),
    .ms_is_load(ms_is_load), .ms_ld_type(ms_ld_type),
    .ms_addr_low(ms_addr_low), .ms_rt_old(ms_rt_old),
    .data_ok(data_ok), .data_rdata(data_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fv;
    logic [4:0]  fd;
    logic [31:0] fdata;
    logic        fstall;
    logic [3:0]  dwen;
    logic [4:0]  dnum;
    logic [31:0] ddata;
  } snap_t;

  exp_t        expq[$];
  logic [31:0] mem_of[logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          issued = 0;
  logic [31:0] pc_next = 32'h0000_1000;
  logic        ok_mode;
  logic        ok_force;
  logic        mon_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Architectural load result from byte lanes and shifts
  function automatic logic [31:0] ref_load(
    input logic [2:0] t, input logic [1:0] n,
    input logic [31:0] mem, input logic [31:0] rt);
    int          ni;
    int          sh;
    logic [31:0] b;
    logic [31:0] h;
    logic [63:0] m64;
    ni = int'(n);
    b  = (mem >> (8 * ni)) & 32'hFF;
    h  = (mem >> (16 * (ni / 2))) & 32'hFFFF;
    case (t)
      3'd1: return (b >= 32'd128) ? b - 32'd256 : b;
      3'd2: return b;
      3'd3: return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4: return h;
      3'd5: begin
        sh  = 8 * (3 - ni);
        m64 = ({32'd0, mem} << sh)
              | ({32'd0, rt} & ((64'd1 << sh) - 64'd1));
        return m64[31:0];
      end
      3'd6: begin
        sh = 8 * ni;
        return (mem >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
      end
      default: return mem;
    endcase
  endfunction

  // Load data responder: returns the word bound to the PC held in WB
  initial begin
    data_ok    = 1'b0;
    data_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      data_ok = ok_mode ? ok_force
                        : ($urandom_range(0, 1) == 1);
      if (mem_of.exists(debug_wb_pc))
        data_rdata = mem_of[debug_wb_pc];
      else
        data_rdata = $urandom;
    end
  end

  // Called just after a rising edge; returns just after acceptance edge
  task automatic issue(
    input logic [4:0] dest, input logic we,
    input logic isld, input logic [2:0] t,
    input logic [1:0] n, input logic [31:0] res,
    input logic [31:0] rt, input logic [31:0] mem,
    input logic lit, input logic [31:0] litv);
    exp_t e;
    int   k;
    pc_next += 32'd4;
    ms_pc       = pc_next;
    ms_dest     = dest;
    ms_rf_we    = we;
    ms_res      = res;
    ms_is_load  = isld;
    ms_ld_type  = t;
    ms_addr_low = n;
    ms_rt_old   = rt;
    ms_valid    = 1'b1;
    if (isld) mem_of[pc_next] = mem;
    e.pc   = pc_next;
    e.wen  = we && (dest != 5'd0);
    e.dest = dest;
    if (lit)       e.data = litv;
    else if (isld) e.data = ref_load(t, n, mem, rt);
    else           e.data = res;
    expq.push_back(e);
    issued++;
    k = 0;
    @(negedge clk);
    while (!wb_allowin && k < 60) begin
      k++;
      @(negedge clk);
    end
    if (!wb_allowin) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout pc %h", pc_next);
    end
    @(posedge clk);
    #1;
    ms_valid = 1'b0;
  endtask

  // Monitor: a retire shows up as retired_cnt stepping on the next edge
  initial begin
    snap_t prev;
    snap_t cur;
    exp_t  e;
    bit    have = 0;
    forever begin
      @(negedge clk);
      cur.cnt    = retired_cnt;
      cur.pc     = debug_wb_pc;
      cur.wen    = rf_wen;
      cur.waddr  = rf_waddr;
      cur.wdata  = rf_wdata;
      cur.fv     = fwd_valid;
      cur.fd     = fwd_dest;
      cur.fdata  = fwd_data;
      cur.fstall = fwd_stall;
      cur.dwen   = debug_wb_rf_wen;
      cur.dnum   = debug_wb_rf_wnum;
      cur.ddata  = debug_wb_rf_wdata;
      if (!mon_en) begin
        have = 0;
      end else begin
        if (have) begin
          if (cur.cnt == prev.cnt + 32'd1) begin
            if (expq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_underflow pc %h", prev.pc);
            end else begin
              e = expq.pop_front();
              chk("pc", prev.pc, e.pc);
              chk("rf_wen", 32'(prev.wen), 32'(e.wen));
              chk("rf_waddr", 32'(prev.waddr), 32'(e.dest));
              chk("rf_wdata", prev.wdata, e.data);
              chk("fwd_valid", 32'(prev.fv), 32'(e.wen));
              chk("fwd_dest", 32'(prev.fd),
                  e.wen ? 32'(e.dest) : 32'd0);
              chk("fwd_data", prev.fdata, e.data);
              chk("fwd_stall", 32'(prev.fstall), 32'd0);
              chk("dbg_wen", 32'(prev.dwen),
                  e.wen ? 32'hF : 32'h0);
              chk("dbg_wnum", 32'(prev.dnum), 32'(e.dest));
              chk("dbg_wdata", prev.ddata, e.data);
            end
          end else begin
            chk("retired_step", cur.cnt, prev.cnt);
            chk("idle_wen", 32'(prev.wen), 32'd0);
          end
        end
        prev = cur;
        have = 1;
      end
    end
  end

  logic [31:0] nxt_pc;

  initial begin
    rstn        = 1'b0;
    ms_valid    = 1'b0;
    ms_pc       = '0;
    ms_dest     = '0;
    ms_rf_we    = 1'b0;
    ms_res      = '0;
    ms_is_load  = 1'b0;
    ms_ld_type  = '0;
    ms_addr_low = '0;
    ms_rt_old   = '0;
    ok_mode     = 1'b1;
    ok_force    = 1'b0;
    mon_en      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    chk("rst_allowin", 32'(wb_allowin), 32'd1);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_fwd_dest", 32'(fwd_dest), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_fwd_stall", 32'(fwd_stall), 32'd0);
    chk("rst_dbg_pc", debug_wb_pc, 32'd0);
    chk("rst_dbg_wen", 32'(debug_wb_rf_wen), 32'd0);
    chk("rst_dbg_wnum", 32'(debug_wb_rf_wnum), 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    @(posedge clk);
    #1 mon_en = 1'b1;

    // ALU result writeback
    issue(5'd8, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678,
          32'd0, 32'd0, 1'b1, 32'h1234_5678);
    @(negedge clk);
    chk("alu_wen", 32'(rf_wen), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd8);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("alu_retired", retired_cnt, 32'd1);
    @(posedge clk);
    #1;

    // Loads with data returning the cycle after capture
    ok_force = 1'b1;
    issue(5'd9, 1'b1, 1'b1, 3'd1, 2'd3, 32'd0, 32'd0,
          32'h80FF_0102, 1'b1, 32'hFFFF_FF80);
    issue(5'd9, 1'b1, 1'b1, 3'd2, 2'd3, 32'd0, 32'd0,
          32'h80FF_0102, 1'b1, 32'h0000_0080);
    issue(5'd10, 1'b1, 1'b1, 3'd5, 2'd1, 32'd0,
          32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'h3344_CCDD);
    issue(5'd11, 1'b1, 1'b1, 3'd6, 2'd2, 32'd0,
          32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hAABB_1122);
    issue(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEAD_BEEF,
          32'd0, 32'd0, 1'b0, 32'd0);

    // Load held three cycles with the next instruction waiting upstream
    ok_force = 1'b0;
    issue(5'd10, 1'b1, 1'b1, 3'd0, 2'd0, 32'd0, 32'd0,
          32'hCAFE_F00D, 1'b0, 32'd0);
    nxt_pc = pc_next + 32'd4;
    fork
      issue(5'd11, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0BAD_F00D,
            32'd0, 32'd0, 1'b0, 32'd0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("hold_allowin", 32'(wb_allowin), 32'd0);
          chk("hold_stall", 32'(fwd_stall), 32'd1);
          chk("hold_wen", 32'(rf_wen), 32'd0);
        end
        ok_force = 1'b1;
        @(negedge clk);
        chk("ok_wen", 32'(rf_wen), 32'd1);
        chk("ok_wdata", rf_wdata, 32'hCAFE_F00D);
        chk("ok_allowin", 32'(wb_allowin), 32'd1);
        ok_force = 1'b0;
      end
    join
    @(negedge clk);
    chk("b2b_pc", debug_wb_pc, nxt_pc);
    @(posedge clk);
    #1;
    ok_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset while a load waits for data
    ok_force = 1'b0;
    issue(5'd12, 1'b1, 1'b1, 3'd0, 2'd0, 32'd0, 32'd0,
          32'h5555_AAAA, 1'b0, 32'd0);
    mon_en = 1'b0;
    rstn   = 1'b0;
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    ok_force = 1'b1;
    @(negedge clk);
    chk("mrst_retired", retired_cnt, 32'd0);
    chk("mrst_allowin", 32'(wb_allowin), 32'd1);
    chk("mrst_wen", 32'(rf_wen), 32'd0);
    chk("mrst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("mrst_stall", 32'(fwd_stall), 32'd0);
    @(negedge clk);
    chk("mrst_wen2", 32'(rf_wen), 32'd0);
    chk("mrst_retired2", retired_cnt, 32'd0);
    expq.delete();
    issued = 0;
    @(posedge clk);
    #1;
    mon_en  = 1'b1;
    ok_mode = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic       ld;
      logic [2:0] t;
      ld = ($urandom_range(0, 1) == 1);
      t  = 3'($urandom_range(0, 6));
      issue(5'($urandom_range(0, 31)),
            ($urandom_range(0, 4) != 0), ld, t,
            2'($urandom_range(0, 3)), $urandom,
            $urandom, $urandom, 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    for (int k = 0; k < 200 && expq.size() > 0; k++)
      @(negedge clk);
    chk("drain", 32'(expq.size()), 32'd0);
    chk("final_retired", retired_cnt, 32'(issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
